// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: issues data-memory transactions over a req/ack bus,
// stalls the front of the pipe while a transaction is in flight, and feeds MEM/WB.
module mem_stage_ctrl #(
    parameter int DW       = 32,
    parameter int RW       = 5,
    parameter int WAIT_MAX = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic          ex_mem_read,
    input  logic          ex_mem_write,
    input  logic          ex_reg_write,
    input  logic [DW-1:0] ex_alu_result,
    input  logic [DW-1:0] ex_store_data,
    input  logic [RW-1:0] ex_rd,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack,
    output logic          stall,
    output logic          wb_en,
    output logic [DW-1:0] wb_rdata,
    output logic [DW-1:0] wb_alu,
    output logic [RW-1:0] wb_rd,
    output logic          mem_err
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [RW-1:0] rd_r, rd_s;
    logic          regw_r, regw_s;
    logic          load_r, load_s;
    logic          req_s, we_s, wb_en_s, mem_err_s;
    logic [DW-1:0] addr_s, wdata_s, wb_rdata_s, wb_alu_s;
    logic [RW-1:0] wb_rd_s;
    logic          memop_s, illegal_s;

    assign memop_s   = ex_mem_read | ex_mem_write;
    assign illegal_s = (ex_mem_read & ex_mem_write) | (memop_s & (ex_alu_result[1:0] != 2'b00));
    assign stall     = ((state_r == IDLE) & ex_valid & memop_s & ~illegal_s) | (state_r == ACCESS);

    // Next-state and next-register values for the FSM and all registered outputs
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        rd_s       = rd_r;
        regw_s     = regw_r;
        load_s     = load_r;
        req_s      = dmem_req;
        we_s       = dmem_we;
        addr_s     = dmem_addr;
        wdata_s    = dmem_wdata;
        wb_en_s    = 1'b0;
        mem_err_s  = 1'b0;
        wb_rdata_s = wb_rdata;
        wb_alu_s   = wb_alu;
        wb_rd_s    = wb_rd;
        case (state_r)
            IDLE: begin
                if (ex_valid) begin
                    if (illegal_s) begin
                        wb_en_s    = 1'b1;
                        mem_err_s  = 1'b1;
                        wb_rd_s    = {RW{1'b0}};
                        wb_alu_s   = ex_alu_result;
                        wb_rdata_s = {DW{1'b0}};
                    end else if (memop_s) begin
                        state_s = ACCESS;
                        cnt_s   = {CW{1'b0}};
                        req_s   = 1'b1;
                        we_s    = ex_mem_write;
                        addr_s  = {ex_alu_result[DW-1:2], 2'b00};
                        wdata_s = ex_store_data;
                        rd_s    = ex_rd;
                        regw_s  = ex_reg_write;
                        load_s  = ex_mem_read;
                    end else begin
                        wb_en_s    = 1'b1;
                        wb_alu_s   = ex_alu_result;
                        wb_rdata_s = {DW{1'b0}};
                        wb_rd_s    = ex_reg_write ? ex_rd : {RW{1'b0}};
                    end
                end else begin
                    wb_en_s = 1'b0;
                end
            end
            ACCESS: begin
                if (dmem_ack) begin
                    // Ack has priority over a timeout landing in the same cycle
                    state_s    = IDLE;
                    req_s      = 1'b0;
                    wb_en_s    = 1'b1;
                    wb_alu_s   = dmem_addr;
                    wb_rdata_s = load_r ? dmem_rdata : {DW{1'b0}};
                    wb_rd_s    = (load_r && regw_r) ? rd_r : {RW{1'b0}};
                end else if (cnt_r == CW'(WAIT_MAX - 1)) begin
                    state_s    = IDLE;
                    req_s      = 1'b0;
                    wb_en_s    = 1'b1;
                    mem_err_s  = 1'b1;
                    wb_alu_s   = dmem_addr;
                    wb_rdata_s = {DW{1'b0}};
                    wb_rd_s    = {RW{1'b0}};
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                req_s   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= {CW{1'b0}};
            rd_r       <= {RW{1'b0}};
            regw_r     <= 1'b0;
            load_r     <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= {DW{1'b0}};
            dmem_wdata <= {DW{1'b0}};
            wb_en      <= 1'b0;
            mem_err    <= 1'b0;
            wb_rdata   <= {DW{1'b0}};
            wb_alu     <= {DW{1'b0}};
            wb_rd      <= {RW{1'b0}};
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            rd_r       <= rd_s;
            regw_r     <= regw_s;
            load_r     <= load_s;
            dmem_req   <= req_s;
            dmem_we    <= we_s;
            dmem_addr  <= addr_s;
            dmem_wdata <= wdata_s;
            wb_en      <= wb_en_s;
            mem_err    <= mem_err_s;
            wb_rdata   <= wb_rdata_s;
            wb_alu     <= wb_alu_s;
            wb_rd      <= wb_rd_s;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: single-cycle vector table plus
// multi-cycle sequences for bus waits, timeout and reset during an access.
module tb_mem_stage_ctrl;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int WAIT_MAX = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          ex_valid, ex_mem_read, ex_mem_write, ex_reg_write;
    logic [DW-1:0] ex_alu_result, ex_store_data;
    logic [RW-1:0] ex_rd;
    logic          dmem_req, dmem_we, dmem_ack;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic          stall, wb_en, mem_err;
    logic [DW-1:0] wb_rdata, wb_alu;
    logic [RW-1:0] wb_rd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.DW(DW), .RW(RW), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall(stall), .wb_en(wb_en), .wb_rdata(wb_rdata), .wb_alu(wb_alu),
        .wb_rd(wb_rd), .mem_err(mem_err)
    );

    typedef struct {
        logic          v, r, w, rw;
        logic [DW-1:0] alu;
        logic [RW-1:0] rd;
        logic          e_wb, e_err, chk_data;
        logic [DW-1:0] e_alu;
        logic [RW-1:0] e_rd;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, r, w, rw, input logic [DW-1:0] alu, sd,
                            input logic [RW-1:0] rd);
        ex_valid = v; ex_mem_read = r; ex_mem_write = w; ex_reg_write = rw;
        ex_alu_result = alu; ex_store_data = sd; ex_rd = rd;
    endtask

    // Runs one memop; ack_at = ACCESS cycle index carrying the ack, -1 for never.
    // Returns at the sample point of the cycle where wb_en is high.
    task automatic mem_op(input logic r, w, rw, input logic [DW-1:0] addr, sd,
                          input logic [RW-1:0] rd, input int ack_at,
                          input logic [DW-1:0] rdata,
                          output int stall_n, output int req_n);
        int  acc;
        bit  got;
        acc = 0; got = 1'b0; stall_n = 0; req_n = 0;
        drive_ex(1'b1, r, w, rw, addr, sd, rd);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc == 0) #1;
            if (cyc > 0 && wb_en) begin
                got = 1'b1;
                break;
            end
            if (stall) stall_n++;
            dmem_ack = 1'b0;
            if (dmem_req) begin
                req_n++;
                if (acc == 0) begin
                    chk("dmem_we", dmem_we, w);
                    chk("dmem_addr", dmem_addr, addr);
                    if (w) chk("dmem_wdata", dmem_wdata, sd);
                end
                ex_valid = 1'b0;
                if (acc == ack_at) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = rdata;
                end
                acc++;
            end
            step();
        end
        dmem_ack = 1'b0;
        ex_valid = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL wb_en_timeout: got no wb_en expected one within 40 cycles");
        end
    endtask

    int s_n, r_n;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1234, 5'd7,  1'b1, 1'b0, 1'b1, 32'h0000_1234, 5'd7};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_CAFE, 5'd9,  1'b1, 1'b0, 1'b1, 32'h0000_CAFE, 5'd0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_5555, 5'd4,  1'b0, 1'b0, 1'b0, 32'h0000_0000, 5'd0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0102, 5'd3,  1'b1, 1'b1, 1'b1, 32'h0000_0102, 5'd0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0041, 5'd2,  1'b1, 1'b1, 1'b1, 32'h0000_0041, 5'd0};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0080, 5'd6,  1'b1, 1'b1, 1'b1, 32'h0000_0080, 5'd0};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0003, 5'd31, 1'b1, 1'b0, 1'b1, 32'h0000_0003, 5'd31};

        rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
        drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        step(); step();
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_we", dmem_we, 1'b0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_wb_en", wb_en, 1'b0);
        chk("rst_err", mem_err, 1'b0);
        chk("rst_rdata", wb_rdata, 32'h0);
        chk("rst_alu", wb_alu, 32'h0);
        chk("rst_rd", wb_rd, 5'd0);
        rst = 1'b0;
        step();

        // Single-cycle IDLE behaviour: non-memops, bubbles and illegal accesses
        for (int i = 0; i < 7; i++) begin
            drive_ex(vecs[i].v, vecs[i].r, vecs[i].w, vecs[i].rw, vecs[i].alu, 32'hFFFF_0000, vecs[i].rd);
            #1;
            chk($sformatf("v%0d_stall", i), stall, 1'b0);
            step();
            chk($sformatf("v%0d_wb_en", i), wb_en, vecs[i].e_wb);
            chk($sformatf("v%0d_err", i), mem_err, vecs[i].e_err);
            chk($sformatf("v%0d_req", i), dmem_req, 1'b0);
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d_alu", i), wb_alu, vecs[i].e_alu);
                chk($sformatf("v%0d_rd", i), wb_rd, vecs[i].e_rd);
                chk($sformatf("v%0d_rdata", i), wb_rdata, 32'h0);
            end
        end
        drive_ex(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        step();
        chk("bubble_wb_en", wb_en, 1'b0);

        // Load with ack in the third ACCESS cycle
        mem_op(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 5'd12, 2, 32'hDEAD_BEEF, s_n, r_n);
        chk("ld_stall_cycles", s_n, 4);
        chk("ld_req_cycles", r_n, 3);
        chk("ld_rdata", wb_rdata, 32'hDEAD_BEEF);
        chk("ld_rd", wb_rd, 5'd12);
        chk("ld_alu", wb_alu, 32'h100);
        chk("ld_err", mem_err, 1'b0);
        chk("ld_stall_done", stall, 1'b0);

        // Back-to-back store with same-cycle ack, issued while the load's wb_en is high
        mem_op(1'b0, 1'b1, 1'b1, 32'h40, 32'hA5A5_A5A5, 5'd8, 0, 32'h1111_1111, s_n, r_n);
        chk("st_stall_cycles", s_n, 2);
        chk("st_req_cycles", r_n, 1);
        chk("st_rd", wb_rd, 5'd0);
        chk("st_rdata", wb_rdata, 32'h0);
        chk("st_err", mem_err, 1'b0);
        step();
        chk("st_wb_pulse", wb_en, 1'b0);

        // Never acked: timeout after WAIT_MAX request cycles
        mem_op(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 5'd5, -1, 32'h0, s_n, r_n);
        chk("to_req_cycles", r_n, WAIT_MAX);
        chk("to_stall_cycles", s_n, WAIT_MAX + 1);
        chk("to_err", mem_err, 1'b1);
        chk("to_rd", wb_rd, 5'd0);
        chk("to_stall_done", stall, 1'b0);
        chk("to_req_done", dmem_req, 1'b0);
        step();
        chk("to_err_pulse", mem_err, 1'b0);

        // Ack arriving on the last allowed cycle beats the timeout
        mem_op(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 5'd9, WAIT_MAX - 1, 32'h0BAD_F00D, s_n, r_n);
        chk("late_ack_req", r_n, WAIT_MAX);
        chk("late_ack_err", mem_err, 1'b0);
        chk("late_ack_rdata", wb_rdata, 32'h0BAD_F00D);
        chk("late_ack_rd", wb_rd, 5'd9);
        step();

        // Reset during ACCESS, followed by a stray ack
        drive_ex(1'b1, 1'b1, 1'b0, 1'b1, 32'h400, 32'h0, 5'd10);
        step();
        chk("rsta_req", dmem_req, 1'b1);
        ex_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rsta_req_drop", dmem_req, 1'b0);
        chk("rsta_stall", stall, 1'b0);
        chk("rsta_wb_en", wb_en, 1'b0);
        chk("rsta_addr", dmem_addr, 32'h0);
        chk("rsta_rd", wb_rd, 5'd0);
        dmem_ack = 1'b1;
        dmem_rdata = 32'h7777_7777;
        step();
        dmem_ack = 1'b0;
        chk("rsta_ack_ignored", wb_en, 1'b0);
        chk("rsta_req_idle", dmem_req, 1'b0);
        drive_ex(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0ABC, 32'h0, 5'd17);
        step();
        ex_valid = 1'b0;
        chk("post_wb_en", wb_en, 1'b1);
        chk("post_alu", wb_alu, 32'h0000_0ABC);
        chk("post_rd", wb_rd, 5'd17);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200us");
        $fatal(1);
    end
endmodule
